// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: CPU clock-enable generator for the board top level.
// Modes: single step (debounced button), N-cycle burst, divided run and full run.
// A synchronous halt gates the enable. A wrapping counter records each issued enable.
// Ports:
//   clk       system clock
//   rst_in    asynchronous active-low reset
//   bttn_in   raw active-low step button, asynchronous to clk
//   mode      00 step, 01 burst, 10 divided run, 11 full run
//   rate_sel  divided-rate select; values past the last rate use the last rate
//   burst_len number of enables issued per burst
//   halt      synchronous enable gate
//   cpu_en    registered single-cycle CPU clock enable
//   busy      a burst is in progress
//   cycle_cnt number of cpu_en pulses issued; wraps
//   cpu_clk   phase output that toggles once per cpu_en
// Optional macro: CPU_CLK_PHASE_EN builds the cpu_clk toggle flop.
// Without it, cpu_clk is tied to 0.
module cpu_clock_ctrl #(
  parameter int DIV_WIDTH   = 18,
  parameter int RATE_STEP   = 3,
  parameter int NUM_RATES   = 4,
  parameter int DEB_WIDTH   = 16,
  parameter int BURST_WIDTH = 8,
  parameter int CNT_WIDTH   = 16,
  localparam int SW = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   bttn_in,
  input  logic [1:0]             mode,
  input  logic [SW-1:0]          rate_sel,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   halt,
  output logic                   cpu_en,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   cycle_cnt,
  output logic                   cpu_clk
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [DIV_WIDTH-1:0]   r_div;
  logic [DIV_WIDTH-1:0]   w_mask;
  logic                   w_tick;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_deb;
  logic                   r_deb_d;
  logic [DEB_WIDTH-1:0]   r_deb_cnt;
  logic                   w_press;
  state_t                 r_state;
  logic [BURST_WIDTH-1:0] r_remain;
  logic                   r_busy;
  logic                   w_mode_burst;
  logic                   w_burst_req;
  logic                   w_req;
  logic                   r_en;
  logic [CNT_WIDTH-1:0]   r_cnt;

  // Rate mask keeps divider bits [tap:0].
  // Scanning upwards makes oversize selects settle on the last rate.
  always_comb begin
    w_mask = '1;
    for (int i = 1; i < NUM_RATES; i++) begin
      if (int'(rate_sel) >= i) begin
        w_mask = {DIV_WIDTH{1'b1}} >> (i * RATE_STEP);
      end
    end
  end

  assign w_tick = &(r_div | ~w_mask);

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_deb     <= 1'b1;
      r_deb_d   <= 1'b1;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= bttn_in;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      if (r_sync2 == r_deb) begin
        r_deb_cnt <= '0;
      end else if (&r_deb_cnt) begin
        r_deb     <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign w_press      = r_deb_d & ~r_deb;
  assign w_mode_burst = (mode == 2'b01);
  assign w_burst_req  = (r_state == S_RUN) & w_tick & ~halt;

  // busy stays high through the final enable.
  // It drops from IDLE one cycle later; on an abort it drops at once.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= S_IDLE;
      r_remain <= '0;
      r_busy   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mode_burst && w_press && (burst_len != '0)) begin
            r_state  <= S_RUN;
            r_remain <= burst_len;
            r_busy   <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_RUN: begin
          if (!w_mode_burst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_burst_req) begin
            r_remain <= r_remain - 1'b1;
            if (r_remain == BURST_WIDTH'(1)) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_req = 1'b0;
    unique case (mode)
      2'b00:   w_req = w_press;
      2'b01:   w_req = w_burst_req;
      2'b10:   w_req = w_tick;
      default: w_req = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_en  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_en <= w_req & ~halt;
      if (r_en) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign cpu_en    = r_en;
  assign busy      = r_busy;
  assign cycle_cnt = r_cnt;

`ifdef CPU_CLK_PHASE_EN
  logic r_clk;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_clk <= 1'b0;
    end else if (r_en) begin
      r_clk <= ~r_clk;
    end
  end

  assign cpu_clk = r_clk;
`else
  assign cpu_clk = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: directed bench for cpu_clock_ctrl.
// It covers step debounce, divided rates, bursts, halt, abort, wrap, reset and the phase output.
module tb_cpu_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst_in = 1'b0;
  logic       bttn_in = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [1:0] rate_sel = 2'b00;
  logic [3:0] burst_len = 4'd0;
  logic       halt = 1'b0;
  logic       cpu_en;
  logic       busy;
  logic [3:0] cycle_cnt;
  logic       cpu_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses, first, last, period, rise, fall;
  bit busy_seen;
  bit busy_prev = 1'b0;

  cpu_clock_ctrl #(
    .DIV_WIDTH(8), .RATE_STEP(2), .NUM_RATES(4),
    .DEB_WIDTH(4), .BURST_WIDTH(4), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_in(rst_in), .bttn_in(bttn_in), .mode(mode),
    .rate_sel(rate_sel), .burst_len(burst_len), .halt(halt),
    .cpu_en(cpu_en), .busy(busy), .cycle_cnt(cycle_cnt), .cpu_clk(cpu_clk)
  );

  always #5 clk = ~clk;

  task automatic clr();
    pulses = 0; first = -1; last = -1; period = 0;
    rise = -1; fall = -1; busy_seen = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (cpu_en === 1'b1) begin
        pulses++;
        if (last >= 0) period = cyc - last;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (busy === 1'b1) begin
        busy_seen = 1'b1;
        if (!busy_prev) rise = cyc;
      end else if (busy_prev) begin
        fall = cyc;
      end
      busy_prev = (busy === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    tick(3);
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%b exp=0", cpu_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (cycle_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cycle_cnt); end
    checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL rst_clk got=%b exp=0", cpu_clk); end
    rst_in = 1'b1;
    tick(4);
  endtask

  task automatic test_step();
    int c0;
    mode = 2'b00;
    clr();
    repeat (3) begin
      bttn_in = 1'b0; tick(3);
      bttn_in = 1'b1; tick(5);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL step_glitch got=%0d exp=0", pulses); end
    clr();
    c0 = cyc;
    bttn_in = 1'b0;
    tick(40);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL step_pulses got=%0d exp=1", pulses); end
    checks++;
    if (first <= c0 || first - c0 > 20) begin
      errors++; $display("FAIL step_latency got=%0d exp=1..20", first - c0);
    end
    checks++; if (cycle_cnt !== 4'd1) begin errors++; $display("FAIL step_cnt1 got=%0d exp=1", cycle_cnt); end
    bttn_in = 1'b1; tick(40);
    bttn_in = 1'b0; tick(40);
    bttn_in = 1'b1; tick(40);
    checks++; if (cycle_cnt !== 4'd2) begin errors++; $display("FAIL step_cnt2 got=%0d exp=2", cycle_cnt); end
  endtask

  task automatic test_divided();
    int p;
    mode = 2'b10;
    for (int s = 0; s < 4; s++) begin
      rate_sel = 2'(s);
      p = 256 >> (2 * s);
      clr();
      tick(3 * p);
      checks++;
      if (period !== p) begin
        errors++; $display("FAIL div_period sel=%0d got=%0d exp=%0d", s, period, p);
      end
    end
    clr();
    tick(64);
    checks++; if (pulses !== 16) begin errors++; $display("FAIL div_count got=%0d exp=16", pulses); end
  endtask

  task automatic test_burst();
    int c0;
    mode = 2'b01; rate_sel = 2'd3; burst_len = 4'd5;
    clr();
    c0 = cyc;
    bttn_in = 1'b0; tick(40);
    bttn_in = 1'b1; tick(40);
    checks++; if (pulses !== 5) begin errors++; $display("FAIL burst_pulses got=%0d exp=5", pulses); end
    checks++; if (period !== 4) begin errors++; $display("FAIL burst_spacing got=%0d exp=4", period); end
    checks++; if (rise !== c0 + 19) begin errors++; $display("FAIL burst_rise got=%0d exp=%0d", rise, c0 + 19); end
    checks++; if (fall !== last + 1) begin errors++; $display("FAIL burst_fall got=%0d exp=%0d", fall, last + 1); end
    burst_len = 4'd15;
    clr();
    bttn_in = 1'b0; tick(22);
    bttn_in = 1'b1; tick(22);
    bttn_in = 1'b0; tick(22);
    bttn_in = 1'b1; tick(60);
    checks++; if (pulses !== 15) begin errors++; $display("FAIL burst_repress got=%0d exp=15", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_idle got=%b exp=0", busy); end
    burst_len = 4'd0;
    clr();
    bttn_in = 1'b0; tick(30);
    bttn_in = 1'b1; tick(30);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL burst_zero got=%0d exp=0", pulses); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL burst_zero_busy got=%b exp=0", busy_seen); end
  endtask

  task automatic test_halt();
    int pb;
    rst_in = 1'b0; mode = 2'b11; halt = 1'b0;
    tick(1);
    rst_in = 1'b1;
    clr(); tick(5);
    checks++; if (pulses !== 5) begin errors++; $display("FAIL halt_pre got=%0d exp=5", pulses); end
    halt = 1'b1;
    clr(); tick(10);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL halt_pulses got=%0d exp=0", pulses); end
    checks++; if (cycle_cnt !== 4'd5) begin errors++; $display("FAIL halt_cnt got=%0d exp=5", cycle_cnt); end
    halt = 1'b0;
    clr(); tick(5);
    checks++; if (pulses !== 5) begin errors++; $display("FAIL halt_resume got=%0d exp=5", pulses); end
    mode = 2'b01; rate_sel = 2'd3; burst_len = 4'd8;
    clr();
    bttn_in = 1'b0; tick(22);
    pb = pulses;
    halt = 1'b1; tick(8);
    checks++; if (pulses !== pb) begin errors++; $display("FAIL halt_burst_gap got=%0d exp=%0d", pulses, pb); end
    halt = 1'b0;
    bttn_in = 1'b1; tick(60);
    checks++; if (pulses !== 8) begin errors++; $display("FAIL halt_burst_total got=%0d exp=8", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL halt_burst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_wrap();
    rst_in = 1'b0; mode = 2'b11;
    tick(1);
    rst_in = 1'b1;
    clr(); tick(20);
    checks++; if (pulses !== 20) begin errors++; $display("FAIL wrap_pulses got=%0d exp=20", pulses); end
    mode = 2'b00;
    tick(1);
    checks++; if (cycle_cnt !== 4'd4) begin errors++; $display("FAIL wrap_cnt got=%0d exp=4", cycle_cnt); end
    checks++; if (pulses !== 20) begin errors++; $display("FAIL wrap_switch got=%0d exp=20", pulses); end
  endtask

  task automatic test_abort();
    mode = 2'b01; rate_sel = 2'd3; burst_len = 4'd15;
    clr();
    bttn_in = 1'b0; tick(24);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got=%b exp=1", busy); end
    mode = 2'b10; tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_drop got=%b exp=0", busy); end
    mode = 2'b01; bttn_in = 1'b1;
    clr(); tick(30);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_resume got=%0d exp=0", pulses); end
  endtask

  task automatic test_async_reset();
    mode = 2'b01; rate_sel = 2'd3; burst_len = 4'd15;
    bttn_in = 1'b0; tick(24);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b exp=1", busy); end
    #1 rst_in = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL areset_en got=%b exp=0", cpu_en); end
    checks++; if (cycle_cnt !== 4'd0) begin errors++; $display("FAIL areset_cnt got=%0d exp=0", cycle_cnt); end
    checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL areset_clk got=%b exp=0", cpu_clk); end
    bttn_in = 1'b1;
    tick(2);
    rst_in = 1'b1;
    clr(); tick(30);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL areset_idle got=%0d exp=0", pulses); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL areset_busy_idle got=%b exp=0", busy_seen); end
  endtask

  task automatic test_phase();
    int toggles, rlast, rper, highs;
    logic prev;
    mode = 2'b10; rate_sel = 2'd3;
    tick(8);
    toggles = 0; rlast = -1; rper = 0; highs = 0;
    prev = cpu_clk;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cpu_clk === 1'b1) highs++;
      if (cpu_clk !== prev) begin
        toggles++;
        if (cpu_clk === 1'b1) begin
          if (rlast >= 0) rper = i - rlast;
          rlast = i;
        end
      end
      prev = cpu_clk;
    end
`ifdef CPU_CLK_PHASE_EN
    checks++; if (toggles !== 16) begin errors++; $display("FAIL phase_toggles got=%0d exp=16", toggles); end
    checks++; if (rper !== 8) begin errors++; $display("FAIL phase_period got=%0d exp=8", rper); end
`else
    checks++; if (highs !== 0) begin errors++; $display("FAIL phase_tied got=%0d exp=0", highs); end
    checks++; if (toggles !== 0) begin errors++; $display("FAIL phase_toggles got=%0d exp=0", toggles); end
`endif
  endtask

  initial begin
    clr();
    test_reset();
    test_step();
    test_divided();
    test_burst();
    test_halt();
    test_wrap();
    test_abort();
    test_async_reset();
    test_phase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Parametrised CPU clock-enable generator for the board top level.
- Replaces the fixed divider tap, the external push-button debouncer and the 2-bit clock-mode mux.
- Modes: single step, N-cycle burst, divided run and full-speed run. Adds halt gating and a retired-cycle counter.
- Sits between the board pins and the CPU core. Its single-cycle cpu_en pulse qualifies the CPU's clk domain.

Parameters:
- DIV_WIDTH, 18: free-running divider width.
- RATE_STEP, 3: tap spacing in bits between adjacent rate selections.
- NUM_RATES, 4: number of selectable divided rates. Requires DIV_WIDTH-1-(NUM_RATES-1)*RATE_STEP >= 0.
- DEB_WIDTH, 16: debounce counter width. The button must be stable for 2^DEB_WIDTH cycles.
- BURST_WIDTH, 8: width of the burst length.
- CNT_WIDTH, 16: width of the retired-cycle counter.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- bttn_in  in  1  raw step button, active-low, asynchronous to clk.
- mode  in  2  00 step, 01 burst, 10 divided run, 11 full run.
- rate_sel  in  clog2(NUM_RATES)  divided-rate select.
- burst_len  in  BURST_WIDTH  number of enables per burst.
- halt  in  1  synchronous gate, e.g. a breakpoint hit.
- cpu_en  out  1  registered single-cycle CPU clock enable.
- busy  out  1  a burst is in progress.
- cycle_cnt  out  CNT_WIDTH  number of cpu_en pulses issued; wraps.
- cpu_clk  out  1  square-wave phase output (see Optional Feature).

Behaviour:
- Reset:
  - Divider, debounce counter, burst counter, cycle_cnt, cpu_en, busy and cpu_clk are all 0.
  - The synchroniser and debounced state reset to "released" (1).
- Divider:
  - Free-running DIV_WIDTH counter, wraps.
  - tap = DIV_WIDTH-1-rate_sel*RATE_STEP.
  - rate_tick = 1 when divider[tap:0] is all ones, giving a period of 2^(tap+1) cycles.
  - rate_sel >= NUM_RATES is clamped to NUM_RATES-1.
- Button path:
  - Two-flop synchroniser.
  - Debounce counter increments while the synchronised value differs from the debounced state and clears when they are equal.
  - At the all-ones count with the inputs still differing, the debounced state takes the new value and the counter clears.
  - press = a 1 to 0 transition of the debounced state; one clk wide.
  - Release produces no action.
- Enable generation, pre-gate request per mode:
  - 00: request = press.
  - 01: burst FSM, see below.
  - 10: request = rate_tick.
  - 11: request = 1 every cycle.
- Burst FSM, states IDLE and RUN:
  - IDLE to RUN on press with burst_len != 0. Remaining count loads burst_len; busy = 1 from the next cycle.
  - Press with burst_len == 0 is ignored.
  - In RUN, each rate_tick with halt = 0 is a request and decrements remaining. The last request returns the FSM to IDLE, with busy = 0 the cycle after that cpu_en.
  - Press during RUN is ignored.
  - A mode change away from 01 during RUN aborts to IDLE, with busy = 0 on the next cycle.
- Halt:
  - cpu_en = registered (request & ~halt), one cycle after the request.
  - Requests during halt are dropped, not queued. A burst keeps its remaining count and resumes on later ticks.
- cycle_cnt increments by 1 on every cpu_en and wraps from all ones to 0.
- Mode change takes effect for the request computed in the same cycle. No spurious pulse is allowed on the switch.
- Asynchronous reset mid-burst: busy and cpu_en drop immediately. After deassertion the block is in IDLE.

Optional Feature:
- Macro CPU_CLK_PHASE_EN.
  - Defined: cpu_clk toggles on every cpu_en, one cycle after the pulse. This gives a legacy phase signal for blocks still using a clk1/clk2 pair.
  - Undefined: cpu_clk is tied to 0 and its toggle flop is not built.

Test Plan (bench parameters: DIV_WIDTH=8, RATE_STEP=2, NUM_RATES=4, DEB_WIDTH=4, BURST_WIDTH=4, CNT_WIDTH=4):
- Step debounce:
  - mode=00; bttn_in low for 40 cycles with 3-cycle glitches beforehand -> exactly one cpu_en, within 16+4 cycles of the stable low; glitches give 0 pulses; cycle_cnt=1.
  - Release then second press -> cycle_cnt=2.
- Divided rates: mode=10, rate_sel=0..3 -> cpu_en periods 256, 64, 16, 4 cycles. rate_sel=3 over 64 cycles gives 16 pulses.
- Burst:
  - mode=01, burst_len=5, rate_sel=3, one press -> exactly 5 pulses at 4-cycle spacing; busy high from the cycle after press until the cycle after the 5th pulse.
  - Press during busy gives no extra pulses.
  - burst_len=0 plus press -> 0 pulses, busy stays 0.
- Halt and abort:
  - mode=11, halt high for 10 cycles -> 0 pulses in that window, cycle_cnt frozen.
  - Burst of 8 with halt pulsed for 2 ticks -> total pulses still 8.
  - Switching mode 01 to 10 mid-burst -> busy=0 next cycle.
- Wrap and reset: mode=11 for 20 cycles -> cycle_cnt wraps 15 to 0 and reads 4. rst_in low mid-burst -> all outputs 0 asynchronously.
- Macro: with CPU_CLK_PHASE_EN, mode=10 and rate_sel=3 -> cpu_clk period 8 cycles. Without the macro, cpu_clk stays at constant 0.
